serial_bit_counter: RTL and testbench

Parametrised multi-cycle bit-statistics engine, the successor to the fixed 32-bit serial ones-counter. It captures a WIDTH-bit word on a load handshake and scans it BPC bits per clock. Depending on a per-operation mode, it reports the count of ones, zeros, trailing zeros or leading zeros. The result is registered and held between operations, with busy/done status, abort support and asynchronous reset; it sits beside datapath blocks that need a low-area popcount or priority count.

---
 rtl/serial_bit_counter.sv | 97 +++++++++
 tb/tb_serial_bit_counter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/serial_bit_counter.sv
// serial_bit_counter: multi-cycle ones/zeros/trailing-zero/leading-zero counter scanning BPC bits per clock
module serial_bit_counter #(
  parameter int WIDTH = 32,
  parameter int BPC = 1,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    count
);
  localparam int N = WIDTH / BPC;
  localparam int BW = $clog2(N + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [1:0] mode_r, mode_r_n;
  logic [CW-1:0] acc, acc_n, count_n, pop, lead;
  logic [BW-1:0] beats, beats_n;
  logic stop, stop_n, hit, done_n;
  logic [BPC-1:0] beat;
  assign busy = state == RUN;
  // lead = zeros before the first one in scan order (MSB-first for mode 11)
  always_comb begin
    beat = mode_r == 2'b11 ? sr[WIDTH-1 -: BPC] : sr[BPC-1:0];
    pop = '0;
    lead = CW'(BPC);
    hit = 1'b0;
    for (int i = 0; i < BPC; i++) begin
      pop = pop + CW'(beat[i]);
      if (!hit && beat[mode_r == 2'b11 ? BPC - 1 - i : i]) begin
        lead = CW'(i);
        hit = 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    sr_n = sr;
    mode_r_n = mode_r;
    acc_n = acc;
    stop_n = stop;
    beats_n = beats;
    count_n = count;
    done_n = 1'b0;
    if (state == IDLE) begin
      if (load) begin
        state_n = RUN;
        sr_n = data_in;
        mode_r_n = mode;
        acc_n = '0;
        stop_n = 1'b0;
        beats_n = BW'(N);
      end
    end else if (abort) begin
      state_n = IDLE;
    end else begin
      sr_n = mode_r == 2'b11 ? sr << BPC : sr >> BPC;
      acc_n = mode_r == 2'b00 ? acc + pop :
              mode_r == 2'b01 ? acc + CW'(BPC) - pop :
              stop ? acc : acc + lead;
      stop_n = stop | (mode_r[1] & hit);
      beats_n = beats - 1'b1;
      if (beats == BW'(1)) begin
        state_n = IDLE;
        count_n = acc_n;
        done_n = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      mode_r <= '0;
      acc <= '0;
      stop <= 1'b0;
      beats <= '0;
      count <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      sr <= sr_n;
      mode_r <= mode_r_n;
      acc <= acc_n;
      stop <= stop_n;
      beats <= beats_n;
      count <= count_n;
      done <= done_n;
    end
  end
endmodule

// File: tb/tb_serial_bit_counter.sv
// tb_serial_bit_counter: random and directed checks of BPC=1 and BPC=4 builds against a word-level model
module tb_serial_bit_counter;
  logic clk = 1'b0;
  logic rst;
  logic load[2], abort[2], busy[2], done[2];
  logic [1:0] mode[2];
  logic [31:0] data[2];
  logic [5:0] count[2];
  int total = 0, bad = 0;
  bit m_busy[2], m_done[2];
  int m_count[2], m_res[2], m_left[2];
  always #5 clk = ~clk;
  serial_bit_counter #(.WIDTH(32), .BPC(1)) u0 (.clk(clk), .rst(rst), .load(load[0]), .mode(mode[0]),
    .data_in(data[0]), .abort(abort[0]), .busy(busy[0]), .done(done[0]), .count(count[0]));
  serial_bit_counter #(.WIDTH(32), .BPC(4)) u1 (.clk(clk), .rst(rst), .load(load[1]), .mode(mode[1]),
    .data_in(data[1]), .abort(abort[1]), .busy(busy[1]), .done(done[1]), .count(count[1]));
  function automatic int nb(int k);
    return k == 0 ? 32 : 8;
  endfunction
  function automatic int stat(logic [31:0] d, logic [1:0] m);
    if (m == 2'd0) return $countones(d);
    if (m == 2'd1) return 32 - $countones(d);
    for (int i = 0; i < 32; i++)
      if (d[m == 2'd2 ? i : 31 - i]) return i;
    return 32;
  endfunction
  always @(posedge clk or posedge rst)
    for (int k = 0; k < 2; k++)
      if (rst) begin
        m_busy[k] <= 0;
        m_done[k] <= 0;
        m_count[k] <= 0;
        m_left[k] <= 0;
      end else if (!m_busy[k]) begin
        m_done[k] <= 0;
        if (load[k]) begin
          m_busy[k] <= 1;
          m_left[k] <= nb(k);
          m_res[k] <= stat(data[k], mode[k]);
        end
      end else if (abort[k]) begin
        m_busy[k] <= 0;
      end else begin
        m_left[k] <= m_left[k] - 1;
        if (m_left[k] == 1) begin
          m_busy[k] <= 0;
          m_done[k] <= 1;
          m_count[k] <= m_res[k];
        end
      end
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(m_busy[k]));
      chk($sformatf("done%0d", k), 32'(done[k]), 32'(m_done[k]));
      chk($sformatf("count%0d", k), 32'(count[k]), m_count[k]);
    end
  endtask
  task automatic run_op(int k, logic [31:0] d, logic [1:0] m, int ab_at, bit la);
    load[k] = 1;
    data[k] = d;
    mode[k] = m;
    abort[k] = la;
    tick();
    for (int b = 1; b <= nb(k); b++) begin
      load[k] = 1'($urandom_range(0, 1));
      data[k] = $urandom;
      mode[k] = 2'($urandom);
      abort[k] = b == ab_at;
      tick();
      if (b == ab_at) break;
    end
    load[k] = 0;
    abort[k] = 0;
  endtask
  task automatic dir(int k, logic [31:0] d, logic [1:0] m, int exp);
    chk("model", stat(d, m), exp);
    run_op(k, d, m, 99, 1'($urandom_range(0, 1)));
    chk($sformatf("lit_count%0d", k), 32'(count[k]), exp);
    chk($sformatf("lit_done%0d", k), 32'(done[k]), 1);
  endtask
  initial begin
    rst = 1;
    for (int k = 0; k < 2; k++) begin
      load[k] = 0; abort[k] = 0; mode[k] = 0; data[k] = 0;
    end
    tick();
    tick();
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_done", 32'(done[0]), 0);
    chk("rst_count", 32'(count[0]), 0);
    rst = 0;
    dir(0, 32'hF0F0_0001, 2'd0, 9);
    dir(0, 32'hF0F0_0001, 2'd1, 23);
    dir(0, 32'h0000_0100, 2'd2, 8);
    dir(0, 32'h0000_0100, 2'd3, 23);
    dir(0, 32'h0000_0000, 2'd2, 32);
    dir(0, 32'h0000_0000, 2'd3, 32);
    dir(0, 32'h8000_0001, 2'd2, 0);
    dir(0, 32'h8000_0001, 2'd3, 0);
    dir(1, 32'hFFFF_FFFF, 2'd0, 32);
    dir(1, 32'h0001_0000, 2'd3, 15);
    dir(0, 32'hF0F0_0001, 2'd0, 9);
    run_op(0, 32'hFFFF_FFFF, 2'd0, 5, 0);
    chk("abort5_count", 32'(count[0]), 9);
    chk("abort5_busy", 32'(busy[0]), 0);
    chk("abort5_done", 32'(done[0]), 0);
    run_op(0, 32'hFFFF_FFFF, 2'd0, 32, 1);
    chk("abortN_count", 32'(count[0]), 9);
    chk("abortN_done", 32'(done[0]), 0);
    load[0] = 1; data[0] = 32'hFFFF_0000; mode[0] = 0;
    tick();
    load[0] = 0;
    repeat (9) tick();
    #2 rst = 1;
    #1;
    chk("arst_busy", 32'(busy[0]), 0);
    chk("arst_done", 32'(done[0]), 0);
    chk("arst_count", 32'(count[0]), 0);
    tick();
    rst = 0;
    dir(0, 32'h0000_0003, 2'd0, 2);
    for (int it = 0; it < 60; it++) begin
      int k, ab;
      logic [31:0] d;
      k = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: d = $urandom;
        1: d = $urandom & $urandom & $urandom;
        2: d = $urandom | $urandom;
        default: d = $urandom_range(0, 1) ? 32'd1 << $urandom_range(0, 31) : 32'd0;
      endcase
      ab = $urandom_range(0, 3) == 0 ? $urandom_range(1, nb(k)) : 99;
      run_op(k, d, 2'($urandom), ab, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        abort[k] = 1'($urandom_range(0, 1));
        tick();
      end
      abort[k] = 0;
    end
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
